// File: rtl/mdu_unit_if.sv
// Request/result bundle between the execute stage and the multiply/divide unit.
interface mdu_unit_if #(
   parameter int unsigned WIDTH = 32
);
   logic             start;
   logic [2:0]       op;
   logic [WIDTH-1:0] A;
   logic [WIDTH-1:0] B;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] HI;
   logic [WIDTH-1:0] LO;

   modport master (output start, op, A, B, input busy, done, HI, LO);
   modport slave  (input start, op, A, B, output busy, done, HI, LO);
endinterface

// File: rtl/mdu_unit.sv
// Multi-cycle multiply/divide unit with HI/LO registers; the result is formed from latched
// operands and committed on the edge where the busy counter reaches zero.
module mdu_unit #(
   parameter int unsigned WIDTH      = 32,
   parameter int unsigned MUL_CYCLES = 5,
   parameter int unsigned DIV_CYCLES = 10
) (
   input logic        clk,
   input logic        reset,
   mdu_unit_if.slave  bus
);
   localparam int unsigned MaxCycles = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
   localparam int unsigned CntW      = $clog2(MaxCycles + 1);

   localparam logic [2:0] OpMult  = 3'b000;
   localparam logic [2:0] OpMultu = 3'b001;
   localparam logic [2:0] OpDiv   = 3'b010;
   localparam logic [2:0] OpDivu  = 3'b011;
   localparam logic [2:0] OpMthi  = 3'b100;
   localparam logic [2:0] OpMtlo  = 3'b101;

   logic [CntW-1:0]    r_cnt;
   logic [2:0]         r_op;
   logic [WIDTH-1:0]   r_a;
   logic [WIDTH-1:0]   r_b;
   logic [WIDTH-1:0]   r_hi;
   logic [WIDTH-1:0]   r_lo;
   logic               r_done;

   logic               w_busy;
   logic [2*WIDTH-1:0] w_prod_s;
   logic [2*WIDTH-1:0] w_prod_u;
   logic               w_neg_a;
   logic               w_neg_b;
   logic [WIDTH-1:0]   w_mag_a;
   logic [WIDTH-1:0]   w_mag_b;
   logic [WIDTH-1:0]   w_div_b;
   logic [WIDTH-1:0]   w_quo_u;
   logic [WIDTH-1:0]   w_rem_u;
   logic [WIDTH-1:0]   w_quo;
   logic [WIDTH-1:0]   w_rem;
   logic               w_div_zero;

   assign w_busy   = (r_cnt != '0);
   // Sign-extending to 2*WIDTH makes the low 2*WIDTH bits of the product the signed result.
   assign w_prod_s = {{WIDTH{r_a[WIDTH-1]}}, r_a} * {{WIDTH{r_b[WIDTH-1]}}, r_b};
   assign w_prod_u = {{WIDTH{1'b0}}, r_a} * {{WIDTH{1'b0}}, r_b};

   // Signed divide runs on magnitudes; MIN / -1 wraps naturally back to MIN with remainder 0.
   assign w_neg_a    = (r_op == OpDiv) & r_a[WIDTH-1];
   assign w_neg_b    = (r_op == OpDiv) & r_b[WIDTH-1];
   assign w_mag_a    = w_neg_a ? -r_a : r_a;
   assign w_mag_b    = w_neg_b ? -r_b : r_b;
   assign w_div_zero = (r_b == '0);
   assign w_div_b    = w_div_zero ? WIDTH'(1) : w_mag_b;
   assign w_quo_u    = w_mag_a / w_div_b;
   assign w_rem_u    = w_mag_a % w_div_b;
   assign w_quo      = (w_neg_a ^ w_neg_b) ? -w_quo_u : w_quo_u;
   assign w_rem      = w_neg_a ? -w_rem_u : w_rem_u;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_cnt  <= '0;
         r_op   <= '0;
         r_a    <= '0;
         r_b    <= '0;
         r_hi   <= '0;
         r_lo   <= '0;
         r_done <= 1'b0;
      end else begin
         r_done <= 1'b0;
         if (w_busy) begin
            r_cnt <= r_cnt - CntW'(1);
            if (r_cnt == CntW'(1)) begin
               r_done <= 1'b1;
               case (r_op)
                  OpMult:  {r_hi, r_lo} <= w_prod_s;
                  OpMultu: {r_hi, r_lo} <= w_prod_u;
                  OpDiv, OpDivu: begin
                     if (!w_div_zero) begin
                        r_hi <= w_rem;
                        r_lo <= w_quo;
                     end
                  end
                  default: ;
               endcase
            end
         end else if (bus.start) begin
            r_op <= bus.op;
            r_a  <= bus.A;
            r_b  <= bus.B;
            case (bus.op)
               OpMult, OpMultu: r_cnt <= CntW'(MUL_CYCLES);
               OpDiv, OpDivu:   r_cnt <= CntW'(DIV_CYCLES);
               OpMthi:          r_hi  <= bus.A;
               OpMtlo:          r_lo  <= bus.A;
               default: ;
            endcase
         end
      end
   end

   assign bus.busy = w_busy;
   assign bus.done = r_done;
   assign bus.HI   = r_hi;
   assign bus.LO   = r_lo;
endmodule

// File: tb/tb_mdu_unit.sv
// Self-checking bench for mdu_unit: vector table plus hand-built multi-cycle sequences,
// with expected HI/LO results queued at issue and popped at the done pulse.
module tb_mdu_unit;
   localparam int W = 32;
   localparam int MulN = 5;
   localparam int DivN = 10;

   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   mdu_unit_if #(.WIDTH(W)) bus ();

   mdu_unit #(
      .WIDTH      (W),
      .MUL_CYCLES (MulN),
      .DIV_CYCLES (DivN)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   typedef struct packed {
      logic [W-1:0] hi;
      logic [W-1:0] lo;
   } res_t;

   typedef struct {
      logic [2:0]   op;
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic [W-1:0] hi;
      logic [W-1:0] lo;
      int           ncyc;
   } vec_t;

   res_t sb[$];
   vec_t vecs[9];
   int total = 0;
   int bad = 0;

   task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   task automatic issue(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
      bus.start = 1'b1;
      bus.op    = op;
      bus.A     = a;
      bus.B     = b;
      @(posedge clk);
      #1 bus.start = 1'b0;
   endtask

   // Counts busy cycles (starting from cnt0) until busy drops, then expects done and pops HI/LO.
   task automatic wait_result(input string name, input int cnt0, input int ncyc);
      int   cnt = cnt0;
      bit   early = 1'b0;
      bit   got = 1'b0;
      res_t e;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (bus.busy) begin
            cnt++;
            if (bus.done) early = 1'b1;
         end else begin
            got = bus.done;
            break;
         end
      end
      check({name, " done"}, 32'(got), 32'd1);
      check({name, " busy_cycles"}, 32'(cnt), 32'(ncyc));
      check({name, " done_during_busy"}, 32'(early), 32'd0);
      if (sb.size() == 0) begin
         total++;
         bad++;
         $display("FAIL %s scoreboard: got empty queue want entry", name);
      end else begin
         e = sb.pop_front();
         check({name, " HI"}, bus.HI, e.hi);
         check({name, " LO"}, bus.LO, e.lo);
      end
   endtask

   task automatic run_op(input string name, input vec_t v);
      sb.push_back({v.hi, v.lo});
      issue(v.op, v.a, v.b);
      wait_result(name, 0, v.ncyc);
      @(negedge clk);
      check({name, " done_one_cycle"}, 32'(bus.done), 32'd0);
   endtask

   initial begin
      int   act;
      vec_t v;
      vecs[0] = '{3'b000, 32'hFFFFFFFE, 32'h00000003, 32'hFFFFFFFF, 32'hFFFFFFFA, MulN};
      vecs[1] = '{3'b001, 32'hFFFFFFFE, 32'h00000003, 32'h00000002, 32'hFFFFFFFA, MulN};
      vecs[2] = '{3'b010, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, DivN};
      vecs[3] = '{3'b011, 32'h00000007, 32'h00000002, 32'h00000001, 32'h00000003, DivN};
      vecs[4] = '{3'b010, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, DivN};
      vecs[5] = '{3'b000, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h3FFFFFFF, 32'h00000001, MulN};
      vecs[6] = '{3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, MulN};
      vecs[7] = '{3'b010, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, DivN};
      vecs[8] = '{3'b010, 32'hFFFFFFF9, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'h00000003, DivN};

      bus.start = 1'b0;
      bus.op    = '0;
      bus.A     = '0;
      bus.B     = '0;
      repeat (2) @(negedge clk);
      check("reset busy", 32'(bus.busy), 32'd0);
      check("reset done", 32'(bus.done), 32'd0);
      check("reset HI", bus.HI, 32'd0);
      check("reset LO", bus.LO, 32'd0);
      reset = 1'b0;
      @(negedge clk);

      for (int i = 0; i < 9; i++) run_op($sformatf("vec%0d", i), vecs[i]);

      // Back-to-back mthi/mtlo preload, each visible right after its edge.
      bus.start = 1'b1;
      bus.op    = 3'b100;
      bus.A     = 32'h11;
      @(posedge clk);
      #1;
      check("mthi HI", bus.HI, 32'h11);
      check("mthi busy", 32'(bus.busy), 32'd0);
      bus.op = 3'b101;
      bus.A  = 32'h22;
      @(posedge clk);
      #1 bus.start = 1'b0;
      check("mtlo LO", bus.LO, 32'h22);
      check("mtlo HI kept", bus.HI, 32'h11);
      @(negedge clk);
      check("mtlo busy", 32'(bus.busy), 32'd0);
      check("mtlo done", 32'(bus.done), 32'd0);

      v = '{3'b011, 32'd5, 32'd0, 32'h11, 32'h22, DivN};
      run_op("divu_by_zero", v);

      issue(3'b110, 32'h55, 32'h66);
      @(negedge clk);
      check("reserved busy", 32'(bus.busy), 32'd0);
      check("reserved HI", bus.HI, 32'h11);
      check("reserved LO", bus.LO, 32'h22);
      issue(3'b111, 32'h77, 32'h88);
      @(negedge clk);
      check("reserved7 busy", 32'(bus.busy), 32'd0);
      check("reserved7 LO", bus.LO, 32'h22);

      // mthi arriving in busy cycle 2 must be dropped.
      sb.push_back({32'd0, 32'd12});
      issue(3'b000, 32'd3, 32'd4);
      @(negedge clk);
      check("ignore busy1", 32'(bus.busy), 32'd1);
      @(negedge clk);
      issue(3'b100, 32'hDEAD, 32'd0);
      wait_result("ignore_mthi", 2, MulN);

      // Request in the done cycle is accepted and overwrites the fresh result.
      sb.push_back({32'd2, 32'd2});
      issue(3'b011, 32'd12, 32'd5);
      wait_result("done_cycle_divu", 0, DivN);
      @(negedge clk);

      // Reset in busy cycle 3 discards the multiply.
      issue(3'b000, 32'd6, 32'd7);
      repeat (3) @(negedge clk);
      reset = 1'b1;
      #1;
      check("rst_mid busy", 32'(bus.busy), 32'd0);
      check("rst_mid done", 32'(bus.done), 32'd0);
      check("rst_mid HI", bus.HI, 32'd0);
      check("rst_mid LO", bus.LO, 32'd0);
      @(negedge clk);
      reset = 1'b0;
      act = 0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         if (bus.done || bus.busy) act++;
      end
      check("rst_mid no_done", 32'(act), 32'd0);
      check("rst_mid LO after", bus.LO, 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/mdu_unit.md
Name: mdu_unit

Overview:
- Parametrised multi-cycle multiply/divide unit with HI/LO result registers.
- Successor to the single-cycle combinational ALU: adds WIDTH generalisation, signed/unsigned multiply and divide, configurable latency, a start/busy/done handshake, and HI/LO move-to ops.
- Sits beside the ALU in the execute stage. The pipeline stalls on busy or start and reads HI/LO directly.

Parameters:
- WIDTH, 32, operand and HI/LO width in bits (≥2)
- MUL_CYCLES, 5, busy cycles for mult/multu (≥1)
- DIV_CYCLES, 10, busy cycles for div/divu (≥1)

Ports:
- clk  input  1  clock, rising edge
- reset  input  1  asynchronous, active-high; clears all state
- start  input  1  request; sampled at the rising edge
- op  input  3  operation code, sampled with start
- A  input  WIDTH  operand A / rs
- B  input  WIDTH  operand B / rt
- busy  output  1  multi-cycle operation in flight
- done  output  1  one-cycle pulse: HI/LO just updated by a mult/div
- HI  output  WIDTH  HI register
- LO  output  WIDTH  LO register

Behaviour:
- Interface: one clock (clk); reset is asynchronous and active-high. While reset is asserted, busy=0, done=0, HI=0, LO=0, and the internal counter and operand latches are 0.
- op encoding:
  - 000 mult: signed, {HI,LO} = A*B (2*WIDTH-bit product)
  - 001 multu: unsigned, {HI,LO} = A*B
  - 010 div: signed, LO = quotient truncated toward zero, HI = remainder (sign of dividend)
  - 011 divu: unsigned, LO = A/B, HI = A%B
  - 100 mthi: HI <= A
  - 101 mtlo: LO <= A
  - 110, 111: reserved, no effect, never busy
- Accept: start=1 and busy=0 at a rising edge.
  - A, B and op are latched at that edge.
  - For mult/div, the counter loads N (MUL_CYCLES or DIV_CYCLES). busy = (counter != 0).
  - busy is high for exactly N cycles starting the cycle after the accept edge.
- Completion:
  - The counter decrements once per edge.
  - On the edge where it goes 1→0, HI/LO are written from the latched operands, busy falls, and done=1 for exactly one cycle.
  - done is registered and zero otherwise.
- Operands are latched at accept. A/B changes during busy have no effect.
- mthi/mtlo:
  - Write on the accept edge itself; visible the next cycle.
  - busy stays 0 and done stays 0.
  - Back-to-back mthi/mtlo on consecutive cycles is legal.
- start while busy=1: ignored entirely, including mthi/mtlo. The requester must hold or stall.
- start in the same cycle done=1: busy is already 0, so the request is accepted normally. The new op runs on the updated HI/LO.
- Divide by zero (div/divu, B=0): the full DIV_CYCLES busy period runs, done pulses, and HI/LO keep their prior values.
- Signed overflow (div, A = most negative value, B = -1): LO = most negative value, HI = 0. No exception.
- Reset mid-operation: busy, done, HI and LO go to 0 immediately (asynchronous). The pending result is discarded and no done is produced after release.
- Arithmetic:
  - Products are computed at full 2*WIDTH precision.
  - The implementation may compute the result at accept and hold it in a result register, or iterate. The externally visible timing above is mandatory either way.

Test Plan:
- Signed multiply: WIDTH=32, mult A=0xFFFFFFFE, B=0x00000003 → busy for 5 cycles, then done pulse, HI=0xFFFFFFFF, LO=0xFFFFFFFA.
- Unsigned multiply: multu with the same operands → HI=0x00000002, LO=0xFFFFFFFA, after the same 5-cycle busy window.
- Divide pair:
  - div A=0xFFFFFFF9 (-7), B=2 → after 10 busy cycles, LO=0xFFFFFFFD, HI=0xFFFFFFFF.
  - divu A=7, B=2 → LO=3, HI=1.
- Divide edge cases:
  - Preload HI=0x11 / LO=0x22 via mthi/mtlo (each visible the next cycle, busy never rises), then divu A=5, B=0 → 10 busy cycles, done pulse, HI=0x11, LO=0x22.
  - div A=0x80000000, B=0xFFFFFFFF → LO=0x80000000, HI=0.
- Start while busy: issue mult 3*4; at busy cycle 2, assert start with mthi A=0xDEAD → ignored, HI=0, LO=12 after completion. Then start divu 12/5 in the done cycle → accepted, LO=2, HI=2 after 10 cycles.
- Reset mid-op: mult 6*7, assert reset in busy cycle 3 for one cycle → busy=0, HI=LO=0 immediately, no done pulse during the following 10 cycles.
